qqspi_responder: RTL and testbench
==================================

Name: qqspi_responder

Overview:
- Synthesizable QSPI/SPI peripheral (responder) that emulates a PSRAM/flash device. It sits on the far end of the qqspi controller bus.
- Decodes single-lane commands 0x02 (write), 0x03 (read), 0x38 (quad write) and 0xEB (fast read quad), and services them from a byte-wide synchronous memory port.
- Used as the on-chip RAM backend and as the self-checking partner for controller verification.
- sclk and cen are oversampled in the clk domain.

Parameters:
ADDR_W, 23, byte-address bits kept from the 24-bit wire address (upper bits ignored)
DEV_ID, 2'b00, cs value this instance answers to
SYNC_STAGES, 0, input synchronizer depth on sclk/cen/cs/sio_in (0 = same clk as controller, 2 = asynchronous source)
DUMMY_CYC, 6, dummy sclk cycles for 0xEB

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
sclk  in  1  SPI clock from controller, idle high
cen  in  1  chip enable, active low
cs  in  2  device select, latched on cen assertion
sio_in  in  4  {sio3,sio2,sio1,sio0} pad inputs
sio_out  out  4  pad output values
sio_oe  out  4  pad output enables
mem_addr  out  ADDR_W  byte address
mem_re  out  1  read strobe; mem_rdata valid next clk
mem_rdata  in  8  read data
mem_we  out  1  write strobe, one clk
mem_wdata  out  8  write byte
busy  out  1  transaction selected and active
err_cmd  out  1  one-clk pulse on unrecognized opcode

Behaviour:
- Reset (async, resetn=0): state IDLE. sio_oe=0, sio_out=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, err_cmd=0, sclk_prev=1.
- Edge detection on synchronized sclk: rise = prev 0, now 1; fall = prev 1, now 0.
- Sampling: input is sampled in the clk cycle where a rise is detected.
- Driving: output advances in the clk cycle after a rise is detected. Output stays stable through the high and low phases, so the controller can sample at the end of the low phase. The design must work at sclk = clk/2.
- Bit order is MSB first.
  - Single lane: input on sio0, output on sio1.
  - Quad: nibble order is high then low, sio3 = MSB.
- States:
  - IDLE: on cen low and cs==DEV_ID, go to CMD and set busy=1. If cs mismatches, go to IGNORE.
  - CMD: 8 single-lane bits.
    - 0x02 or 0x03: single-lane address (24 rises).
    - 0x38 or 0xEB: quad address (6 rises).
    - Any other opcode: pulse err_cmd, go to IGNORE.
  - ADDR: shift 24 bits and keep the low ADDR_W bits.
    - On the final address rise: write commands go to WR_DATA. Read commands assert mem_re with the combinationally formed address in that same cycle.
    - 0xEB then goes to DUMMY. 0x03 goes straight to RD_DATA.
  - DUMMY: count DUMMY_CYC rises with sio_oe=0. After the last rise, set sio_oe=1111 and drive the first nibble from mem_rdata (bypass path).
  - RD_DATA:
    - 0x03 uses sio_oe=0010; 0xEB uses sio_oe=1111.
    - First bit comes from mem_rdata, then from a shift register.
    - When the first bit of a byte goes out, prefetch addr+1 (mem_re).
    - Burst continues until cen rises.
  - WR_DATA: assemble bytes (8 single or 2 quad rises). On byte completion, pulse mem_we with mem_addr=current and mem_wdata=byte, then increment the address.
  - IGNORE: sio_oe=0, no memory access, wait for cen high.
- Address increments modulo 2^ADDR_W (wrap to 0).
- cen high, any state and any time: next clk goes to IDLE with sio_oe=0 and busy=0. A partial byte is discarded without mem_we. A pending prefetch result is dropped.
- A simultaneous byte completion and cen rise in the same clk: commit the byte.
- sclk edges while cen is high are ignored.

Decomposition:
- Package qqspi_pkg holds:
  - opcode constants CMD_WRITE=0x02, CMD_READ=0x03, CMD_QUAD_WRITE=0x38, CMD_FAST_READ_QUAD=0xEB;
  - state encoding (IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE);
  - address bit count 24.
- Sub-module qqspi_sync_edge handles the SYNC_STAGES-deep synchronizer plus the rise/fall detector. It is instantiated for sclk; the same synchronizer, without the edge detector, is used for cen, cs and sio_in.

Test Plan:
- Quad write: cs=0, 0x38, addr 0x000004, data 0xDEADBEEF -> four mem_we pulses, addr 4,5,6,7, bytes DE,AD,BE,EF; sio_oe stays 0.
- Fast read quad: memory[4..7]=DE AD BE EF, 0xEB addr 0x000004, 6 dummy clocks -> sio_oe=0 during dummy, then nibbles D,E,A,D,B,E,E,F; controller-side word 0xDEADBEEF at sclk=clk/2.
- Single write then read: 0x02 addr 0x000003 byte 0x5A -> one mem_we at addr 3. Then 0x03 addr 0x000003 -> 0x5A on sio1 with sio_oe=0010 starting on the first fall after the address.
- Wrap: 0x38 at addr 0x7FFFFF, 2 bytes 0x11 0x22 -> mem_we at 0x7FFFFF then 0x000000.
- Abort: 0x38 addr 0, 1.5 bytes, then cen high -> exactly one mem_we (byte 0); back to IDLE with busy=0 next clk. Async reset mid-read -> all outputs at reset values immediately.
- Reject: opcode 0x9F -> err_cmd one-clk pulse, no mem_re/mem_we, sio_oe=0. cs=2'b01 with DEV_ID=0 -> no response, busy=0.

Source files
------------

// File: rtl/qqspi_pkg.sv
// Shared opcodes, FSM state encoding and opcode helpers for the qqspi responder.
package qqspi_pkg;

  localparam logic [7:0] CMD_WRITE          = 8'h02;
  localparam logic [7:0] CMD_READ           = 8'h03;
  localparam logic [7:0] CMD_QUAD_WRITE     = 8'h38;
  localparam logic [7:0] CMD_FAST_READ_QUAD = 8'hEB;

  localparam int ADDR_BITS = 24;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RD_DATA,
    WR_DATA,
    IGNORE
  } state_e;

  function automatic logic is_quad_cmd(input logic [7:0] op);
    return (op == CMD_QUAD_WRITE) || (op == CMD_FAST_READ_QUAD);
  endfunction

  function automatic logic is_read_cmd(input logic [7:0] op);
    return (op == CMD_READ) || (op == CMD_FAST_READ_QUAD);
  endfunction

  function automatic logic is_valid_cmd(input logic [7:0] op);
    return (op == CMD_WRITE) || (op == CMD_READ) ||
           (op == CMD_QUAD_WRITE) || (op == CMD_FAST_READ_QUAD);
  endfunction

endpackage

// File: rtl/qqspi_sync_edge.sv
// Optional multi-stage synchronizer for {sclk, data} plus sclk rising-edge detector.
module qqspi_sync_edge #(
  parameter int         W       = 7,
  parameter int         STAGES  = 0,
  parameter logic [W:0] RST_VAL = '1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         sclk_i,
  input  logic [W-1:0] data_i,
  output logic         rise_o,
  output logic [W-1:0] data_o
);

  logic [W:0] raw;
  logic [W:0] synced;
  logic       sclk_prev_q;

  assign raw = {sclk_i, data_i};

  if (STAGES == 0) begin : g_bypass
    assign synced = raw;
  end else begin : g_sync
    logic [W:0] stage_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < STAGES; i++) stage_q[i] <= RST_VAL;
      end else begin
        stage_q[0] <= raw;
        for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign synced = stage_q[STAGES-1];
  end

  // sclk idles high, so the previous sample starts high to avoid a false rise out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sclk_prev_q <= 1'b1;
    else         sclk_prev_q <= synced[W];
  end

  assign rise_o = synced[W] & ~sclk_prev_q;
  assign data_o = synced[W-1:0];

endmodule

// File: rtl/qqspi_responder.sv
// QSPI/SPI responder emulating a PSRAM: decodes 0x02/0x03/0x38/0xEB and
// services them from a byte-wide synchronous memory port.
module qqspi_responder
  import qqspi_pkg::*;
#(
  parameter int         ADDR_W      = 23,
  parameter logic [1:0] DEV_ID      = 2'b00,
  parameter int         SYNC_STAGES = 0,
  parameter int         DUMMY_CYC   = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sclk,
  input  logic              cen,
  input  logic [1:0]        cs,
  input  logic [3:0]        sio_in,
  output logic [3:0]        sio_out,
  output logic [3:0]        sio_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              err_cmd
);

  localparam int         SH_W       = ADDR_W - 1;
  localparam logic [5:0] DUMMY_LAST = 6'(DUMMY_CYC - 1);

  logic       rise, cen_s;
  logic [1:0] cs_s;
  logic [3:0] sio_s;
  logic [6:0] sync_data;

  qqspi_sync_edge #(
    .W       (7),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (8'hC0)
  ) u_sclk_sync (
    .clk_i  (clk),
    .rst_ni (resetn),
    .sclk_i (sclk),
    .data_i ({cen, cs, sio_in}),
    .rise_o (rise),
    .data_o (sync_data)
  );

  assign {cen_s, cs_s, sio_s} = sync_data;

  state_e              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [SH_W-1:0]     sh_q, sh_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [7:0]          out_q, out_d;
  logic                load_q, load_d;
  logic                err_q, err_d;

  logic                quad, act;
  logic [5:0]          cnt_inc;
  logic [ADDR_W-1:0]   shifted;
  logic [7:0]          rd_byte;

  assign quad    = is_quad_cmd(cmd_q) && (state_q != CMD);
  assign act     = rise & ~cen_s;
  assign cnt_inc = cnt_q + (quad ? 6'd4 : 6'd1);
  assign shifted = quad ? {sh_q[SH_W-4:0], sio_s} : {sh_q, sio_s[0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      addr_q  <= '0;
      cmd_q   <= '0;
      out_q   <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      out_q   <= out_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    out_d     = out_q;
    load_d    = load_q;
    err_d     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = '0;

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        load_d = 1'b0;
        if (!cen_s) state_d = (cs_s == DEV_ID) ? CMD : IGNORE;
      end
      CMD: if (act) begin
        sh_d  = shifted[SH_W-1:0];
        cnt_d = cnt_inc;
        if (cnt_inc == 6'd8) begin
          cnt_d = '0;
          cmd_d = shifted[7:0];
          if (is_valid_cmd(shifted[7:0])) begin
            state_d = ADDR;
          end else begin
            err_d   = 1'b1;
            state_d = IGNORE;
          end
        end
      end
      // The read launch uses the freshly shifted address so data is back one clk later.
      ADDR: if (act) begin
        sh_d  = shifted[SH_W-1:0];
        cnt_d = cnt_inc;
        if (cnt_inc == 6'(ADDR_BITS)) begin
          cnt_d  = '0;
          addr_d = shifted;
          if (is_read_cmd(cmd_q)) begin
            mem_re   = 1'b1;
            mem_addr = shifted;
            load_d   = 1'b1;
            state_d  = (cmd_q == CMD_FAST_READ_QUAD) ? DUMMY : RD_DATA;
          end else begin
            state_d = WR_DATA;
          end
        end
      end
      DUMMY: if (act) begin
        if (cnt_q == DUMMY_LAST) begin
          cnt_d   = '0;
          state_d = RD_DATA;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      // A load cycle captures the fetched byte and prefetches the next address.
      RD_DATA: begin
        if (load_q) begin
          out_d  = mem_rdata;
          load_d = 1'b0;
          if (!cen_s) begin
            mem_re   = 1'b1;
            mem_addr = addr_q + 1'b1;
            addr_d   = addr_q + 1'b1;
          end
        end else if (act) begin
          out_d = quad ? {out_q[3:0], 4'b0000} : {out_q[6:0], 1'b0};
          cnt_d = cnt_inc;
          if (cnt_inc == 6'd8) begin
            cnt_d  = '0;
            load_d = 1'b1;
          end
        end
      end
      WR_DATA: if (rise) begin
        sh_d  = shifted[SH_W-1:0];
        cnt_d = cnt_inc;
        if (cnt_inc == 6'd8) begin
          cnt_d     = '0;
          mem_we    = 1'b1;
          mem_wdata = shifted[7:0];
          addr_d    = addr_q + 1'b1;
        end
      end
      IGNORE: ;
      default: state_d = IDLE;
    endcase

    if (cen_s) state_d = IDLE;
  end

  always_comb begin
    rd_byte = load_q ? mem_rdata : out_q;
    sio_oe  = '0;
    sio_out = '0;
    if (state_q == RD_DATA) begin
      if (quad) begin
        sio_oe  = 4'hF;
        sio_out = rd_byte[7:4];
      end else begin
        sio_oe  = 4'b0010;
        sio_out = {2'b00, rd_byte[7], 1'b0};
      end
    end
  end

  assign busy    = state_q inside {CMD, ADDR, DUMMY, RD_DATA, WR_DATA};
  assign err_cmd = err_q;

endmodule

// File: tb/tb_qqspi_responder.sv
// Directed bench: drives the qqspi bus at sclk = clk/2 against a byte memory model.
module tb_qqspi_responder;

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic        sclk   = 1'b1;
  logic        cen    = 1'b1;
  logic [1:0]  cs     = 2'b00;
  logic [3:0]  sio_in = 4'h0;
  logic [3:0]  sio_out, sio_oe;
  logic [22:0] mem_addr;
  logic        mem_re, mem_we, busy, err_cmd;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  mem_wdata;

  int testsRun = 0, testsFailed = 0;
  int reCount = 0, errCount = 0, oeCount = 0, busyCount = 0;
  logic [31:0] wrLog [$];
  logic [7:0]  memModel [int];

  qqspi_responder dut (
    .clk(clk), .resetn(resetn), .sclk(sclk), .cen(cen), .cs(cs),
    .sio_in(sio_in), .sio_out(sio_out), .sio_oe(sio_oe),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy), .err_cmd(err_cmd)
  );

  always #5 clk = ~clk;

  // Synchronous byte memory: read data appears the clk after mem_re and holds.
  always @(posedge clk) begin
    if (mem_we) begin
      memModel[int'(mem_addr)] = mem_wdata;
      wrLog.push_back({1'b0, mem_addr, mem_wdata});
    end
    if (mem_re) mem_rdata <= memModel.exists(int'(mem_addr)) ? memModel[int'(mem_addr)] : 8'h00;
  end

  always @(negedge clk) begin
    if (mem_re)       reCount++;
    if (err_cmd)      errCount++;
    if (sio_oe != 0)  oeCount++;
    if (busy)         busyCount++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sclk period: fall with new data, sample mid low phase, then rise.
  task automatic applyStimulus(input logic [3:0] drive, output logic [3:0] seenOut, output logic [3:0] seenOe);
    sclk   = 1'b0;
    sio_in = drive;
    @(negedge clk);
    seenOut = sio_out;
    seenOe  = sio_oe;
    tick();
    sclk = 1'b1;
    tick();
  endtask

  task automatic startTxn(input logic [1:0] sel);
    cs   = sel;
    sclk = 1'b1;
    cen  = 1'b0;
    tick();
  endtask

  task automatic endTxn();
    cen    = 1'b1;
    sclk   = 1'b1;
    sio_in = 4'h0;
    tick();
    tick();
  endtask

  task automatic sendSingle(input logic [7:0] b);
    logic [3:0] o, e;
    for (int i = 7; i >= 0; i--) applyStimulus({3'b000, b[i]}, o, e);
  endtask

  task automatic sendQuad(input logic [7:0] b);
    logic [3:0] o, e;
    applyStimulus(b[7:4], o, e);
    applyStimulus(b[3:0], o, e);
  endtask

  task automatic sendAddr(input logic [23:0] a, input logic quadMode);
    logic [3:0] o, e;
    if (quadMode) for (int i = 5; i >= 0; i--) applyStimulus(a[i*4 +: 4], o, e);
    else          for (int i = 23; i >= 0; i--) applyStimulus({3'b000, a[i]}, o, e);
  endtask

  function automatic logic [31:0] wrAt(input int i);
    return (i < wrLog.size()) ? wrLog[i] : 32'hFFFF_FFFF;
  endfunction

  initial begin
    logic [3:0]  o, e;
    logic [31:0] word;
    logic [7:0]  rbyte;
    int base, n, reBase, errBase, oeBase, busyBase;

    repeat (3) tick();
    checkOutput("reset sio_oe",    sio_oe,    4'h0);
    checkOutput("reset sio_out",   sio_out,   4'h0);
    checkOutput("reset mem_re",    mem_re,    1'b0);
    checkOutput("reset mem_we",    mem_we,    1'b0);
    checkOutput("reset mem_addr",  mem_addr,  23'h0);
    checkOutput("reset mem_wdata", mem_wdata, 8'h00);
    checkOutput("reset busy",      busy,      1'b0);
    checkOutput("reset err_cmd",   err_cmd,   1'b0);
    resetn = 1'b1;
    tick();
    tick();

    // Quad write 0xDEADBEEF at address 4
    base = wrLog.size(); oeBase = oeCount;
    startTxn(2'b00);
    checkOutput("qw busy", busy, 1'b1);
    sendSingle(8'h38);
    sendAddr(24'h000004, 1'b1);
    sendQuad(8'hDE); sendQuad(8'hAD); sendQuad(8'hBE); sendQuad(8'hEF);
    endTxn();
    checkOutput("qw count", wrLog.size() - base, 4);
    checkOutput("qw w0", wrAt(base),     32'h0000_04DE);
    checkOutput("qw w1", wrAt(base + 1), 32'h0000_05AD);
    checkOutput("qw w2", wrAt(base + 2), 32'h0000_06BE);
    checkOutput("qw w3", wrAt(base + 3), 32'h0000_07EF);
    checkOutput("qw oe", oeCount - oeBase, 0);
    checkOutput("qw idle busy", busy, 1'b0);

    // Fast read quad from address 4
    startTxn(2'b00);
    sendSingle(8'hEB);
    sendAddr(24'h000004, 1'b1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'h0, o, e);
      if (e == 4'h0) n++;
    end
    checkOutput("eb dummy oe", n, 6);
    n = 0; word = '0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'h0, o, e);
      word = {word[27:0], o};
      if (e == 4'hF) n++;
    end
    endTxn();
    checkOutput("eb data", word, 32'hDEAD_BEEF);
    checkOutput("eb oe", n, 8);

    // Single write 0x5A at 3, then single read back
    base = wrLog.size();
    startTxn(2'b00);
    sendSingle(8'h02);
    sendAddr(24'h000003, 1'b0);
    sendSingle(8'h5A);
    endTxn();
    checkOutput("sw count", wrLog.size() - base, 1);
    checkOutput("sw w0", wrAt(base), 32'h0000_035A);
    startTxn(2'b00);
    sendSingle(8'h03);
    sendAddr(24'h000003, 1'b0);
    n = 0; rbyte = '0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'h0, o, e);
      rbyte = {rbyte[6:0], o[1]};
      if (e == 4'b0010) n++;
    end
    endTxn();
    checkOutput("sr data", rbyte, 8'h5A);
    checkOutput("sr oe", n, 8);

    // Address wrap at the top of the 23-bit space
    base = wrLog.size();
    startTxn(2'b00);
    sendSingle(8'h38);
    sendAddr(24'h7FFFFF, 1'b1);
    sendQuad(8'h11); sendQuad(8'h22);
    endTxn();
    checkOutput("wrap count", wrLog.size() - base, 2);
    checkOutput("wrap w0", wrAt(base),     32'h7FFF_FF11);
    checkOutput("wrap w1", wrAt(base + 1), 32'h0000_0022);

    // Abort after 1.5 bytes: only the completed byte is written
    base = wrLog.size();
    startTxn(2'b00);
    sendSingle(8'h38);
    sendAddr(24'h000000, 1'b1);
    sendQuad(8'hA5);
    applyStimulus(4'h3, o, e);
    checkOutput("abort busy pre", busy, 1'b1);
    cen = 1'b1;
    tick();
    checkOutput("abort busy post", busy, 1'b0);
    checkOutput("abort oe", sio_oe, 4'h0);
    tick();
    checkOutput("abort count", wrLog.size() - base, 1);
    checkOutput("abort w0", wrAt(base), 32'h0000_00A5);

    // Async reset in the middle of a single read
    startTxn(2'b00);
    sendSingle(8'h03);
    sendAddr(24'h000004, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'h0, o, e);
    checkOutput("rst pre oe", sio_oe, 4'b0010);
    #2 resetn = 1'b0;
    #1;
    checkOutput("rst oe",      sio_oe,   4'h0);
    checkOutput("rst out",     sio_out,  4'h0);
    checkOutput("rst busy",    busy,     1'b0);
    checkOutput("rst mem_re",  mem_re,   1'b0);
    checkOutput("rst mem_addr", mem_addr, 23'h0);
    cen = 1'b1; sclk = 1'b1;
    tick();
    resetn = 1'b1;
    tick();
    tick();

    // Unknown opcode 0x9F
    base = wrLog.size(); reBase = reCount; errBase = errCount; oeBase = oeCount;
    startTxn(2'b00);
    sendSingle(8'h9F);
    checkOutput("rej busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(4'hF, o, e);
    endTxn();
    checkOutput("rej err pulses", errCount - errBase, 1);
    checkOutput("rej re", reCount - reBase, 0);
    checkOutput("rej we", wrLog.size() - base, 0);
    checkOutput("rej oe", oeCount - oeBase, 0);

    // Device select mismatch: no response at all
    reBase = reCount; oeBase = oeCount; busyBase = busyCount;
    startTxn(2'b01);
    sendSingle(8'h03);
    sendAddr(24'h000004, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(4'h0, o, e);
    endTxn();
    checkOutput("cs busy", busyCount - busyBase, 0);
    checkOutput("cs re", reCount - reBase, 0);
    checkOutput("cs oe", oeCount - oeBase, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
